// File: rtl/edge_seq.sv
// edge_seq: top-level sequencer for the edge-detection chip.
// Drives the band-wise buffer load, four windowed passes (Gauss, Sobel,
// NMS, hysteresis) with optional drain gaps, then the raster output phase.
module edge_seq #(
    parameter int unsigned IMG_W    = 20,
    parameter int unsigned IMG_H    = 20,
    parameter int unsigned PIPE_LAT = 2,
    localparam int unsigned NBANDS  = IMG_H / 5,
    localparam int unsigned BW      = (NBANDS > 1) ? $clog2(NBANDS) : 1,
    localparam int unsigned CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int unsigned RW      = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int unsigned DW      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_end,
    output logic          buf_wr_en,
    output logic [BW-1:0] buf_wr_band,
    output logic [CW-1:0] buf_wr_col,
    output logic [3:0]    stage_en,
    output logic [RW-1:0] scan_row,
    output logic [CW-1:0] scan_col,
    output logic          readable,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          done,
    output logic          load_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    stg_q, stg_d;
    logic [BW-1:0] band_q, band_d;
    logic [CW-1:0] wcol_q, wcol_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          load_err_q, load_err_d;

    logic          buf_wr_en_q, buf_wr_en_d;
    logic [BW-1:0] buf_wr_band_q, buf_wr_band_d;
    logic [CW-1:0] buf_wr_col_q, buf_wr_col_d;
    logic [3:0]    stage_en_q, stage_en_d;
    logic [RW-1:0] scan_row_q, scan_row_d;
    logic [CW-1:0] scan_col_q, scan_col_d;
    logic          readable_q, readable_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    logic          done_q, done_d;

    logic last_beat, last_pix, col_wrap;

    // Boundary decodes for the load beat counter and the shared raster counter
    always_comb begin
        last_beat = (band_q == BW'(NBANDS - 1)) && (wcol_q == CW'(IMG_W - 1));
        col_wrap  = (col_q == CW'(IMG_W - 1));
        last_pix  = (row_q == RW'(IMG_H - 1)) && col_wrap;
    end

    // Next-state, counter updates, and output decode from the next state
    always_comb begin
        state_d    = state_q;
        stg_d      = stg_q;
        band_d     = band_q;
        wcol_d     = wcol_q;
        row_d      = row_q;
        col_d      = col_q;
        drain_d    = drain_q;
        load_err_d = load_err_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_LOAD;
                band_d  = '0;
                wcol_d  = '0;
            end
            S_LOAD: begin
                if (load_end || last_beat) begin
                    state_d = S_SCAN;
                    stg_d   = 2'd0;
                    row_d   = '0;
                    col_d   = '0;
                    band_d  = '0;
                    wcol_d  = '0;
                    if (!load_end) begin
                        load_err_d = 1'b1;
                    end
                end else if (wcol_q == CW'(IMG_W - 1)) begin
                    wcol_d = '0;
                    band_d = band_q + BW'(1);
                end else begin
                    wcol_d = wcol_q + CW'(1);
                end
            end
            S_SCAN: begin
                if (last_pix) begin
                    row_d = '0;
                    col_d = '0;
                    if (PIPE_LAT != 0) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(PIPE_LAT - 1);
                    end else if (stg_q == 2'd3) begin
                        state_d = S_OUT;
                    end else begin
                        stg_d = stg_q + 2'd1;
                    end
                end else if (col_wrap) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    row_d = '0;
                    col_d = '0;
                    if (stg_q == 2'd3) begin
                        state_d = S_OUT;
                    end else begin
                        state_d = S_SCAN;
                        stg_d   = stg_q + 2'd1;
                    end
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_OUT: begin
                if (last_pix) begin
                    state_d = S_DONE;
                    row_d   = '0;
                    col_d   = '0;
                end else if (col_wrap) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        buf_wr_en_d   = (state_d == S_LOAD);
        buf_wr_band_d = (state_d == S_LOAD) ? band_d : '0;
        buf_wr_col_d  = (state_d == S_LOAD) ? wcol_d : '0;
        stage_en_d    = (state_d == S_SCAN) ? 4'(4'b0001 << stg_d) : 4'b0000;
        scan_row_d    = (state_d == S_SCAN) ? row_d : '0;
        scan_col_d    = (state_d == S_SCAN) ? col_d : '0;
        readable_d    = (state_d == S_OUT);
        out_row_d     = (state_d == S_OUT) ? row_d : '0;
        out_col_d     = (state_d == S_OUT) ? col_d : '0;
        done_d        = (state_d == S_DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            stg_q         <= 2'd0;
            band_q        <= '0;
            wcol_q        <= '0;
            row_q         <= '0;
            col_q         <= '0;
            drain_q       <= '0;
            load_err_q    <= 1'b0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_band_q <= '0;
            buf_wr_col_q  <= '0;
            stage_en_q    <= 4'b0000;
            scan_row_q    <= '0;
            scan_col_q    <= '0;
            readable_q    <= 1'b0;
            out_row_q     <= '0;
            out_col_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stg_q         <= stg_d;
            band_q        <= band_d;
            wcol_q        <= wcol_d;
            row_q         <= row_d;
            col_q         <= col_d;
            drain_q       <= drain_d;
            load_err_q    <= load_err_d;
            buf_wr_en_q   <= buf_wr_en_d;
            buf_wr_band_q <= buf_wr_band_d;
            buf_wr_col_q  <= buf_wr_col_d;
            stage_en_q    <= stage_en_d;
            scan_row_q    <= scan_row_d;
            scan_col_q    <= scan_col_d;
            readable_q    <= readable_d;
            out_row_q     <= out_row_d;
            out_col_q     <= out_col_d;
            done_q        <= done_d;
        end
    end

    assign buf_wr_en   = buf_wr_en_q;
    assign buf_wr_band = buf_wr_band_q;
    assign buf_wr_col  = buf_wr_col_q;
    assign stage_en    = stage_en_q;
    assign scan_row    = scan_row_q;
    assign scan_col    = scan_col_q;
    assign readable    = readable_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign done        = done_q;
    assign load_err    = load_err_q;

endmodule
